// File: rtl/counter_readout.sv
// Counter IC readback: settle, double-sample until stable, present on valid/ready.
// Optional COUNTER_READOUT_SYNC_EN adds a two-flop input synchroniser on CNT_Q.
module counter_readout #(
    parameter int NUM_CNT       = 4,
    parameter int CNT_WIDTH     = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int MAX_RETRY     = 3
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         START,
    input  logic                         CTRL_ACTIVE,
    input  logic [NUM_CNT*CNT_WIDTH-1:0] CNT_Q,
    output logic [NUM_CNT*CNT_WIDTH-1:0] DATA,
    output logic                         DATA_VALID,
    input  logic                         DATA_READY,
    output logic                         BUSY,
    output logic                         ERROR
);

    localparam int W = NUM_CNT * CNT_WIDTH;

`ifdef COUNTER_READOUT_SYNC_EN
    // Two extra quiet cycles cover the synchroniser depth.
    localparam int SETTLE_LOAD = SETTLE_CYCLES + 1;
`else
    localparam int SETTLE_LOAD = SETTLE_CYCLES - 1;
`endif

    localparam int SW = (SETTLE_LOAD < 1) ? 1 : $clog2(SETTLE_LOAD + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_LOAD);
    localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMP_A,
        SAMP_B,
        HOLD
    } state_t;

    state_t        state;
    logic [SW-1:0] settle_cnt;
    logic [RW-1:0] retry_cnt;
    logic [RW-1:0] retry_next;
    logic [W-1:0]  snap_a;
    logic [W-1:0]  bus;

`ifdef COUNTER_READOUT_SYNC_EN
    logic [W-1:0] sync_1;
    logic [W-1:0] sync_2;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= CNT_Q;
            sync_2 <= sync_1;
        end
    end

    assign bus = sync_2;
`else
    assign bus = CNT_Q;
`endif

    assign retry_next = retry_cnt + 1'b1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            settle_cnt <= '0;
            retry_cnt  <= '0;
            snap_a     <= '0;
            DATA       <= '0;
            DATA_VALID <= 1'b0;
            BUSY       <= 1'b0;
            ERROR      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        state      <= SETTLE;
                        settle_cnt <= SETTLE_INIT;
                        retry_cnt  <= '0;
                        ERROR      <= 1'b0;
                        BUSY       <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (CTRL_ACTIVE) begin
                        settle_cnt <= SETTLE_INIT;
                    end else if (settle_cnt == '0) begin
                        state <= SAMP_A;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                SAMP_A: begin
                    if (CTRL_ACTIVE) begin
                        state      <= SETTLE;
                        settle_cnt <= SETTLE_INIT;
                    end else begin
                        snap_a <= bus;
                        state  <= SAMP_B;
                    end
                end
                SAMP_B: begin
                    // An abort by CTRL_ACTIVE is not a failed compare.
                    if (CTRL_ACTIVE) begin
                        state      <= SETTLE;
                        settle_cnt <= SETTLE_INIT;
                    end else if (bus == snap_a) begin
                        DATA       <= snap_a;
                        DATA_VALID <= 1'b1;
                        state      <= HOLD;
                    end else if (retry_next == RETRY_LAST) begin
                        retry_cnt  <= retry_next;
                        DATA       <= bus;
                        ERROR      <= 1'b1;
                        DATA_VALID <= 1'b1;
                        state      <= HOLD;
                    end else begin
                        retry_cnt  <= retry_next;
                        settle_cnt <= SETTLE_INIT;
                        state      <= SETTLE;
                    end
                end
                HOLD: begin
                    if (DATA_READY) begin
                        DATA_VALID <= 1'b0;
                        BUSY       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_readout.sv
// Self-checking bench for counter_readout: directed scenarios plus random traffic vs a quiet-run model.
module tb_counter_readout;

    localparam int NUM_CNT       = 4;
    localparam int CNT_WIDTH     = 8;
    localparam int SETTLE_CYCLES = 4;
    localparam int MAX_RETRY     = 3;

`ifdef COUNTER_READOUT_SYNC_EN
    localparam int WIN          = SETTLE_CYCLES + 2;
    localparam int LAT_NOM      = 8;
    localparam int LAT_RESTART  = 11;
    localparam int LAT_UNSTABLE = 24;
`else
    localparam int WIN          = SETTLE_CYCLES;
    localparam int LAT_NOM      = 6;
    localparam int LAT_RESTART  = 9;
    localparam int LAT_UNSTABLE = 18;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic        CTRL_ACTIVE = 1'b0;
    logic        DATA_READY = 1'b0;
    logic [31:0] CNT_Q = 32'hDEADBEEF;
    logic [31:0] DATA;
    logic        DATA_VALID;
    logic        BUSY;
    logic        ERROR;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    counter_readout #(
        .NUM_CNT      (NUM_CNT),
        .CNT_WIDTH    (CNT_WIDTH),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .CTRL_ACTIVE(CTRL_ACTIVE),
        .CNT_Q      (CNT_Q),
        .DATA       (DATA),
        .DATA_VALID (DATA_VALID),
        .DATA_READY (DATA_READY),
        .BUSY       (BUSY),
        .ERROR      (ERROR)
    );

    always #5 CLK = ~CLK;

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Model: a read waits for WIN consecutive quiet edges, then snaps and compares.
    typedef enum {P_IDLE, P_QUIET, P_SNAP, P_CMP, P_HOLD} phase_t;
    phase_t      ph = P_IDLE;
    logic [31:0] m_data = '0;
    logic [31:0] m_snap = '0;
    logic [31:0] hist0 = '0;
    logic [31:0] hist1 = '0;
    logic [31:0] eff;
    logic        m_valid = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_err = 1'b0;
    int          m_quiet = 0;
    int          m_tries = 0;

    initial forever begin
        @(posedge CLK or negedge RST);
        if (!RST) begin
            ph = P_IDLE; m_data = '0; m_snap = '0; hist0 = '0; hist1 = '0;
            m_valid = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_quiet = 0; m_tries = 0;
        end else begin
`ifdef COUNTER_READOUT_SYNC_EN
            eff = hist1;
`else
            eff = CNT_Q;
`endif
            hist1 = hist0;
            hist0 = CNT_Q;
            case (ph)
                P_IDLE: if (START) begin
                    ph = P_QUIET; m_quiet = 0; m_tries = 0; m_err = 1'b0; m_busy = 1'b1;
                end
                P_QUIET: begin
                    m_quiet = CTRL_ACTIVE ? 0 : m_quiet + 1;
                    if (m_quiet == WIN) ph = P_SNAP;
                end
                P_SNAP: begin
                    if (CTRL_ACTIVE) begin ph = P_QUIET; m_quiet = 0; end
                    else begin m_snap = eff; ph = P_CMP; end
                end
                P_CMP: begin
                    if (CTRL_ACTIVE) begin
                        ph = P_QUIET; m_quiet = 0;
                    end else if (eff == m_snap) begin
                        m_data = m_snap; m_valid = 1'b1; ph = P_HOLD;
                    end else begin
                        m_tries++;
                        if (m_tries == MAX_RETRY) begin
                            m_data = eff; m_err = 1'b1; m_valid = 1'b1; ph = P_HOLD;
                        end else begin
                            ph = P_QUIET; m_quiet = 0;
                        end
                    end
                end
                P_HOLD: if (DATA_READY) begin
                    m_valid = 1'b0; m_busy = 1'b0; ph = P_IDLE;
                end
                default: ph = P_IDLE;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issues one START and waits for DATA_VALID; optional CTRL_ACTIVE window and re-pulsed START by offset.
    task automatic run_read(input bit toggle, input bit ready, input int ca_lo, input int ca_hi,
                            input int re_off, output int lat, output int nvalid,
                            output logic [31:0] d, output logic e);
        int s;
        int k;
        bit found;
        lat = -1; nvalid = 0; found = 0; d = '0; e = 1'b0;
        DATA_READY = ready;
        @(negedge CLK);
        START = 1'b1;
        if (toggle) CNT_Q = ~CNT_Q;
        s = cyc + 1;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge CLK);
            k = cyc + 1 - s;
            START = (re_off >= 0 && k == re_off);
            CTRL_ACTIVE = (k >= ca_lo && k <= ca_hi);
            if (toggle) CNT_Q = ~CNT_Q;
            #2;
            if (DATA_VALID) begin
                found = 1; lat = cyc - s; nvalid = 1; d = DATA; e = ERROR;
            end
        end
        START = 1'b0;
        CTRL_ACTIVE = 1'b0;
        check("read_completes", 32'(found), 32'd1);
        if (found && ready) begin
            for (int i = 0; i < 12; i++) begin
                @(negedge CLK); #2;
                if (DATA_VALID) nvalid++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int nv;
        logic [31:0] d;
        logic e;

        fork
            forever begin
                @(negedge CLK); #2;
                if (RST) begin
                    check("model_data",  DATA,              m_data);
                    check("model_valid", 32'(DATA_VALID),   32'(m_valid));
                    check("model_busy",  32'(BUSY),         32'(m_busy));
                    check("model_error", 32'(ERROR),        32'(m_err));
                end
            end
        join_none

        // Reset held with a busy bus and a START pulse.
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            START = (i == 1);
            #2;
            check("rst_data", DATA, 32'h0);
            check("rst_valid", 32'(DATA_VALID), 32'd0);
            check("rst_busy", 32'(BUSY), 32'd0);
            check("rst_error", 32'(ERROR), 32'd0);
        end
        @(negedge CLK);
        START = 1'b0;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        #2;
        check("post_rst_busy", 32'(BUSY), 32'd0);
        check("post_rst_valid", 32'(DATA_VALID), 32'd0);

        // Nominal read.
        CNT_Q = 32'h01020304;
        run_read(1'b0, 1'b1, -1, -1, -1, lat, nv, d, e);
        check("nom_latency", 32'(lat), 32'(LAT_NOM));
        check("nom_data", d, 32'h01020304);
        check("nom_error", 32'(e), 32'd0);
        check("nom_one_valid", 32'(nv), 32'd1);
        check("nom_busy_after", 32'(BUSY), 32'd0);

        // Settle restart by CTRL_ACTIVE, with an ignored START while busy.
        CNT_Q = 32'hA5A55A5A;
        run_read(1'b0, 1'b1, 2, 3, 5, lat, nv, d, e);
        check("restart_latency", 32'(lat), 32'(LAT_RESTART));
        check("restart_data", d, 32'hA5A55A5A);
        check("restart_one_valid", 32'(nv), 32'd1);

        // Unstable bus then backpressure.
        CNT_Q = 32'h0;
        run_read(1'b1, 1'b0, -1, -1, -1, lat, nv, d, e);
        check("unstable_latency", 32'(lat), 32'(LAT_UNSTABLE));
        check("unstable_error", 32'(e), 32'd1);
        check("unstable_data", d, 32'hFFFFFFFF);
        CNT_Q = 32'h55555555;
        repeat (20) @(negedge CLK);
        #2;
        check("bp_data_held", DATA, 32'hFFFFFFFF);
        check("bp_error_held", 32'(ERROR), 32'd1);
        check("bp_valid_held", 32'(DATA_VALID), 32'd1);
        @(negedge CLK);
        DATA_READY = 1'b1;
        @(negedge CLK); #2;
        check("bp_handshake_busy", 32'(BUSY), 32'd0);
        check("bp_handshake_valid", 32'(DATA_VALID), 32'd0);
        check("bp_error_until_start", 32'(ERROR), 32'd1);
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        #2;
        check("start_clears_error", 32'(ERROR), 32'd0);
        check("start_sets_busy", 32'(BUSY), 32'd1);
        repeat (15) @(negedge CLK);

        // START on the handshake edge is dropped; the next cycle's START is taken.
        CNT_Q = 32'h0A0B0C0D;
        run_read(1'b0, 1'b0, -1, -1, -1, lat, nv, d, e);
        check("hs_data", d, 32'h0A0B0C0D);
        @(negedge CLK);
        DATA_READY = 1'b1;
        START = 1'b1;
        @(negedge CLK); #2;
        check("hs_start_ignored", 32'(BUSY), 32'd0);
        @(negedge CLK);
        START = 1'b0;
        #2;
        check("b2b_start_taken", 32'(BUSY), 32'd1);
        repeat (15) @(negedge CLK);

        // Reset in the middle of a read.
        CNT_Q = 32'h11223344;
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        @(negedge CLK); RST = 1'b0;
        #2;
        check("midrst_busy", 32'(BUSY), 32'd0);
        check("midrst_valid", 32'(DATA_VALID), 32'd0);
        @(negedge CLK); RST = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK); #2;
            check("midrst_no_stale_valid", 32'(DATA_VALID), 32'd0);
        end
        run_read(1'b0, 1'b1, -1, -1, -1, lat, nv, d, e);
        check("midrst_latency", 32'(lat), 32'(LAT_NOM));
        check("midrst_data", d, 32'h11223344);

        // Random traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            RST = ($urandom_range(0, 599) != 0);
            START = ($urandom_range(0, 5) == 0);
            CTRL_ACTIVE = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 3) == 0) CNT_Q = $urandom;
            DATA_READY = ($urandom_range(0, 2) != 0);
        end
        @(negedge CLK);
        RST = 1'b1; START = 1'b0; CTRL_ACTIVE = 1'b0; DATA_READY = 1'b1;
        repeat (20) @(negedge CLK);
        #3;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
